// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One multiply takes exactly four iteration cycles; a single ripple-carry adder
// performs every partial-product accumulation.
//
// Ports:
//   clock    in   1  rising-edge clock
//   reset    in   1  synchronous, active-high reset
//   start    in   1  begin a multiply (accepted in IDLE or DONE)
//   a        in   4  multiplicand, captured on accepted start
//   b        in   4  multiplier, captured on accepted start
//   product  out  8  last completed product, registered
//   busy     out  1  high while iterating
//   done     out  1  one-cycle pulse when product is newly valid

// Single-bit full adder.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));
endmodule

// 4-bit ripple-carry adder built from a full_adder chain.
module ripple_carry_adder4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      full_adder u_fa (
         .x    (x[i]),
         .y    (y[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   assign cout = carry[4];
endmodule

module shift_add_multiplier (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] product,
   output logic       busy,
   output logic       done
);
   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROD_W = 8;
   localparam int unsigned CNT_W  = 2;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     m_q, m_d;
   logic [OP_W-1:0]     q_q, q_d;
   logic [OP_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PROD_W-1:0]   product_q, product_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [OP_W-1:0]     add_sum;
   logic                add_cout;
   logic [OP_W:0]       partial;     // {C,S} for this iteration
   logic [2*OP_W:0]     shifted;     // {C,S,Q} >> 1

   // The only adder in the block: A + M, carry-in tied low.
   ripple_carry_adder4 u_adder (
      .x    (acc_q),
      .y    (m_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Conditional add selected by the multiplier LSB, then 9-bit right shift.
   always_comb begin
      partial = {1'b0, acc_q};
      if (q_q[0]) begin
         partial = {add_cout, add_sum};
      end
      shifted = {partial, q_q} >> 1;
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               count_d = '0;
               state_d = CALC;
               busy_d  = 1'b1;
            end
         end
         CALC: begin
            acc_d   = shifted[2*OP_W-1:OP_W];
            q_d     = shifted[OP_W-1:0];
            count_d = CNT_W'(count_q + CNT_W'(1));
            if (count_q == LAST_ITER) begin
               state_d   = DONE;
               product_d = shifted[PROD_W-1:0];
               done_d    = 1'b1;
            end else begin
               busy_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset overrides everything including start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign product = product_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: the driver predicts each accepted
// multiply (a*b, completion edge) into a queue; a monitor checks product, busy
// and done after every rising edge against that prediction.
module tb_shift_add_multiplier;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] product;
   logic       busy;
   logic       done;

   shift_add_multiplier dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] prod;
      int         done_edge;
   } exp_t;

   exp_t sb[$];
   int   cyc       = 0;
   int   next_free = 0;
   int   n_vec     = 0;
   int   n_err     = 0;
   bit   armed     = 1'b0;
   logic [7:0] exp_prod = 8'h00;

   always @(posedge clock) cyc <= cyc + 1;

   // Apply one cycle of inputs and predict the DUT's reaction at the next edge.
   task automatic drive(input logic r, input logic s, input logic [3:0] aa, input logic [3:0] bb);
      int e;
      @(negedge clock);
      reset = r;
      start = s;
      a     = aa;
      b     = bb;
      e     = cyc + 1;
      if (r) begin
         while (sb.size() > 0 && sb[sb.size()-1].done_edge >= e) void'(sb.pop_back());
         next_free = e + 1;
      end else if (s && e >= next_free) begin
         exp_t t;
         t.prod      = 8'(int'(aa) * int'(bb));
         t.done_edge = e + 4;
         sb.push_back(t);
         next_free   = e + 5;
      end
   endtask

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   // Monitor: compares outputs shortly after each rising edge.
   always @(posedge clock) begin
      logic exp_busy;
      logic exp_done;
      #1;
      if (reset) armed = 1'b1;
      if (armed) begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         if (reset) begin
            exp_prod = 8'h00;
         end else if (sb.size() > 0) begin
            if (cyc == sb[0].done_edge) begin
               exp_done = 1'b1;
               exp_prod = sb[0].prod;
               void'(sb.pop_front());
            end else if (cyc >= sb[0].done_edge - 4 && cyc < sb[0].done_edge) begin
               exp_busy = 1'b1;
            end
         end
         check("done", int'(done), int'(exp_done));
         check("busy", int'(busy), int'(exp_busy));
         check("product", int'(product), int'(exp_prod));
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      repeat (2) drive(1'b1, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b1, 4'd5, 4'd5);                 // start discarded under reset
      repeat (2) drive(1'b0, 1'b0, 4'd0, 4'd0);

      drive(1'b0, 1'b1, 4'd3, 4'd5);                 // 0x0F
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);
      drive(1'b0, 1'b1, 4'd15, 4'd15);               // 0xE1
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);
      drive(1'b0, 1'b1, 4'd9, 4'd0);                 // zero still takes 4 cycles
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);

      drive(1'b0, 1'b1, 4'd6, 4'd7);                 // 0x2A, ignore restart mid-CALC
      drive(1'b0, 1'b0, 4'd1, 4'd1);
      drive(1'b0, 1'b1, 4'd1, 4'd1);
      drive(1'b0, 1'b0, 4'd1, 4'd1);
      repeat (4) drive(1'b0, 1'b0, 4'd0, 4'd0);

      drive(1'b0, 1'b1, 4'd12, 4'd11);               // aborted by reset
      drive(1'b0, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);

      repeat (20) drive(1'b0, 1'b1, 4'd2, 4'd3);     // back-to-back, done every 5
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);

      // Exhaustive sweep with start held high.
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 4'(i >> 4), 4'(i));
      end
      repeat (6) drive(1'b0, 1'b0, 4'd0, 4'd0);

      // Random traffic with occasional resets and operand churn.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      repeat (8) drive(1'b0, 1'b0, 4'd0, 4'd0);

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
